// File: rtl/dvvm_pkg.sv
// Shared definitions for the dense vector-vector multiplier front end:
// default widths, sequencer state encoding, buffer select codes, accumulator sizing.
package dvvm_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Width that holds vec_len full-scale products without wrapping.
  function automatic int calc_acc_w(input int data_w, input int vec_len);
    return 2 * data_w + ((vec_len > 1) ? $clog2(vec_len) : 0);
  endfunction

endpackage

// File: rtl/vector_buffer.sv
// VEC_LEN x DATA_W operand register file: async clear, one write port,
// one combinational read port. Out-of-range writes are dropped, reads return 0.
module vector_buffer #(
  parameter int VEC_LEN = 8,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [VEC_LEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VEC_LEN; i++) mem_q[i] <= '0;
    end else if (wr_en_i && (int'(wr_addr_i) < VEC_LEN)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = (int'(rd_addr_i) < VEC_LEN) ? mem_q[rd_addr_i] : '0;

endmodule

// File: rtl/dot_product_sequencer.sv
// Feeds A/B element pairs to the multi-cycle MAC one at a time and accumulates the dot product.
// Optional watchdog in WAIT is built only when MAC_TIMEOUT_EN is defined.
module dot_product_sequencer
  import dvvm_pkg::*;
#(
  parameter int VEC_LEN        = 8,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = 3,
  parameter int ACC_W          = calc_acc_w(DATA_W, VEC_LEN),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                wr_sel,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                start,
  output logic                busy,
  output logic                mac_enable,
  output logic [DATA_W-1:0]   mac_a,
  output logic [DATA_W-1:0]   mac_b,
  input  logic [2*DATA_W-1:0] mac_result,
  input  logic                mac_done,
  output logic [ACC_W-1:0]    dot_result,
  output logic                dot_valid,
  output logic                mac_timeout
);

  if (TIMEOUT_CYCLES < 1 || (1 << ADDR_W) < VEC_LEN) begin : g_bad_params
    $error("dot_product_sequencer: invalid TIMEOUT_CYCLES or ADDR_W too small for VEC_LEN");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0]  acc_q, acc_d, dot_result_q, dot_result_d, sum;
  logic [DATA_W-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic [DATA_W-1:0] buf_a_rd, buf_b_rd, fwd_a, fwd_b;
  logic              wr_fire, last_elem, tmo_hit;

  assign wr_fire = wr_en && (state_q == IDLE);

  vector_buffer #(.VEC_LEN(VEC_LEN), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf_a (
    .clk(clk), .rst(rst),
    .wr_en_i(wr_fire && (wr_sel == SEL_A)), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(idx_d), .rd_data_o(buf_a_rd)
  );

  vector_buffer #(.VEC_LEN(VEC_LEN), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf_b (
    .clk(clk), .rst(rst),
    .wr_en_i(wr_fire && (wr_sel == SEL_B)), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(idx_d), .rd_data_o(buf_b_rd)
  );

  // Operands are captured on entry to ISSUE; a write landing with start is forwarded.
  assign fwd_a = (wr_fire && (wr_sel == SEL_A) && (wr_addr == idx_d)) ? wr_data : buf_a_rd;
  assign fwd_b = (wr_fire && (wr_sel == SEL_B) && (wr_addr == idx_d)) ? wr_data : buf_b_rd;

  assign sum       = acc_q + ACC_W'(mac_result);
  assign last_elem = (idx_q == ADDR_W'(VEC_LEN - 1));

`ifdef MAC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q;

  always_comb begin
    tmo_cnt_d = '0;
    tmo_hit   = 1'b0;
    if (state_q == WAIT && !mac_done) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      tmo_hit   = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_q | tmo_hit;
    end
  end

  assign mac_timeout = timeout_q;
`else
  assign tmo_hit     = 1'b0;
  assign mac_timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    dot_result_d = dot_result_q;
    mac_a_d      = mac_a_q;
    mac_b_d      = mac_b_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          idx_d   = '0;
          mac_a_d = fwd_a;
          mac_b_d = fwd_b;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mac_done) begin
          acc_d = sum;
          if (last_elem) begin
            dot_result_d = sum;
            state_d      = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            mac_a_d = fwd_a;
            mac_b_d = fwd_b;
            state_d = ISSUE;
          end
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      dot_result_q <= '0;
      mac_a_q      <= '0;
      mac_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      dot_result_q <= dot_result_d;
      mac_a_q      <= mac_a_d;
      mac_b_q      <= mac_b_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign mac_enable = (state_q == ISSUE);
  assign dot_valid  = (state_q == DONE);
  assign mac_a      = mac_a_q;
  assign mac_b      = mac_b_q;
  assign dot_result = dot_result_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench for dot_product_sequencer with a behavioural multi-cycle MAC model.
// The watchdog scenario runs only when MAC_TIMEOUT_EN is defined.
module tb_dot_product_sequencer;

  localparam int VEC_LEN = 8;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 3;
  localparam int ACC_W   = 19;

  logic              clk, rst;
  logic              wr_en, wr_sel, start;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy, mac_enable, dot_valid, mac_timeout;
  logic [DATA_W-1:0] mac_a, mac_b;
  logic [15:0]       mac_result;
  logic              mac_done;
  logic [ACC_W-1:0]  dot_result;

  dot_product_sequencer #(
    .VEC_LEN(VEC_LEN), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .mac_enable(mac_enable),
    .mac_a(mac_a), .mac_b(mac_b), .mac_result(mac_result), .mac_done(mac_done),
    .dot_result(dot_result), .dot_valid(dot_valid), .mac_timeout(mac_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC model knobs, written only by the stimulus process
  int macLatency = 1;
  bit latVary = 1'b0;
  bit withholdDone = 1'b0;
  int spuriousReq = 0;

  // MAC model state, written only by the model process
  logic [7:0] capA, capB;
  int remain = 0, issueNum = 0, stableErrors = 0, doneCount = 0, spuriousSeen = 0;
  bit pending = 1'b0;

  // MAC model: captures operands on mac_enable, answers after the latency, checks hold
  always @(negedge clk) begin
    if (rst) begin
      pending  = 1'b0;
      mac_done = 1'b0;
    end else begin
      if (mac_done) mac_done = 1'b0;
      if (pending) begin
        if (mac_a !== capA || mac_b !== capB) stableErrors++;
        remain--;
        if (remain <= 0 && !withholdDone) begin
          mac_result = capA * capB;
          mac_done   = 1'b1;
          pending    = 1'b0;
          doneCount++;
        end
      end
      if (mac_enable) begin
        capA    = mac_a;
        capB    = mac_b;
        pending = 1'b1;
        remain  = latVary ? (2 + (issueNum % 4)) : macLatency;
        issueNum++;
      end
      if (spuriousReq != spuriousSeen) begin
        spuriousSeen = spuriousReq;
        mac_result   = 16'hFFFF;
        mac_done     = 1'b1;
      end
    end
  end

  // Output monitor
  int enableCount = 0, validCount = 0;
  logic [ACC_W-1:0] lastResult = '0;
  always @(negedge clk) begin
    if (mac_enable) enableCount++;
    if (dot_valid) begin
      validCount++;
      lastResult = dot_result;
    end
  end

  int checks = 0, passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic writeElem(input logic sel, input int addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = ADDR_W'(addr);
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic waitValid(input int v0, input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (validCount != v0) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Start a run and wait for it to finish plus a settling window
  task automatic runDot(input string name, input logic [ACC_W-1:0] expRes);
    int e0, v0;
    bit got;
    e0 = enableCount;
    v0 = validCount;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitValid(v0, 400, got);
    checkOutput({name, " valid seen"}, 32'(got), 32'd1);
    for (int c = 0; c < 20; c++) tick();
    checkOutput({name, " result"}, 32'(lastResult), 32'(expRes));
    checkOutput({name, " enables"}, 32'(enableCount - e0), 32'(VEC_LEN));
    checkOutput({name, " valids"}, 32'(validCount - v0), 32'd1);
  endtask

  typedef struct packed {
    logic [7:0][7:0] a;
    logic [7:0][7:0] b;
    logic [7:0]      lat;
    logic            vary;
    logic [ACC_W-1:0] exp;
  } vec_t;

  vec_t  vecs[5];
  string vecName[5];

  task automatic applyStimulus(input int k);
    macLatency = int'(vecs[k].lat);
    latVary    = vecs[k].vary;
    for (int i = 0; i < VEC_LEN; i++) begin
      writeElem(1'b0, i, vecs[k].a[i]);
      writeElem(1'b1, i, vecs[k].b[i]);
    end
    stableErrors = 0;
    runDot(vecName[k], vecs[k].exp);
    checkOutput({vecName[k], " operands held"}, 32'(stableErrors), 32'd0);
  endtask

  initial begin
    int v0, d0;
    bit got;
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    mac_result = '0; mac_done = 1'b0;

    // zero, ramp, max (varied latency), squares, mixed
    for (int i = 0; i < VEC_LEN; i++) begin
      vecs[0].a[i] = 8'd0;         vecs[0].b[i] = 8'd0;
      vecs[1].a[i] = 8'(i + 1);    vecs[1].b[i] = 8'd1;
      vecs[2].a[i] = 8'd255;       vecs[2].b[i] = 8'd255;
      vecs[3].a[i] = 8'(i + 1);    vecs[3].b[i] = 8'(i + 1);
      vecs[4].a[i] = 8'(2 * i);    vecs[4].b[i] = 8'(8 - i);
    end
    vecs[0].lat = 8'd1; vecs[0].vary = 1'b0; vecs[0].exp = 19'd0;      vecName[0] = "zero";
    vecs[1].lat = 8'd3; vecs[1].vary = 1'b0; vecs[1].exp = 19'd36;     vecName[1] = "ramp";
    vecs[2].lat = 8'd2; vecs[2].vary = 1'b1; vecs[2].exp = 19'd520200; vecName[2] = "max";
    vecs[3].lat = 8'd1; vecs[3].vary = 1'b0; vecs[3].exp = 19'd204;    vecName[3] = "squares";
    vecs[4].lat = 8'd4; vecs[4].vary = 1'b0; vecs[4].exp = 19'd168;    vecName[4] = "mixed";

    tick();
    tick();
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset mac_enable", 32'(mac_enable), 32'd0);
    checkOutput("reset dot_valid", 32'(dot_valid), 32'd0);
    checkOutput("reset dot_result", 32'(dot_result), 32'd0);
    checkOutput("reset mac_a", 32'(mac_a), 32'd0);
    checkOutput("reset mac_b", 32'(mac_b), 32'd0);
    checkOutput("reset mac_timeout", 32'(mac_timeout), 32'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 5; k++) applyStimulus(k);
    checkOutput("result held", 32'(dot_result), 32'd168);

    // Ramp reload, then write A[0]=100 in the same cycle as start: 36 - 1 + 100
    macLatency = 2;
    latVary = 1'b0;
    for (int i = 0; i < VEC_LEN; i++) begin
      writeElem(1'b0, i, 8'(i + 1));
      writeElem(1'b1, i, 8'd1);
    end
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'd100;
    runDot("write with start", 19'd135);
    wr_en = 1'b0;
    writeElem(1'b0, 0, 8'd1);

    // start pulsed while busy is ignored
    v0 = validCount;
    start = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    waitValid(v0, 400, got);
    for (int c = 0; c < 150; c++) tick();
    checkOutput("start while busy valids", 32'(validCount - v0), 32'd1);
    checkOutput("start while busy result", 32'(lastResult), 32'd36);

    // writes while busy are dropped
    v0 = validCount;
    start = 1'b1;
    tick();
    start = 1'b0;
    writeElem(1'b0, 0, 8'd99);
    writeElem(1'b1, 3, 8'd77);
    writeElem(1'b0, 7, 8'd200);
    waitValid(v0, 400, got);
    checkOutput("busy-write run result", 32'(lastResult), 32'd36);
    for (int c = 0; c < 5; c++) tick();
    runDot("after busy writes", 19'd36);

    // spurious mac_done in IDLE
    v0 = validCount;
    spuriousReq++;
    for (int c = 0; c < 5; c++) tick();
    checkOutput("spurious busy", 32'(busy), 32'd0);
    checkOutput("spurious valids", 32'(validCount - v0), 32'd0);
    checkOutput("spurious result", 32'(dot_result), 32'd36);
    runDot("after spurious", 19'd36);

    // reset after the 3rd mac_done
    v0 = validCount;
    d0 = doneCount;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && (doneCount - d0) < 3; c++) tick();
    checkOutput("third done reached", 32'(doneCount - d0), 32'd3);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midrun rst busy", 32'(busy), 32'd0);
    checkOutput("midrun rst mac_enable", 32'(mac_enable), 32'd0);
    checkOutput("midrun rst dot_result", 32'(dot_result), 32'd0);
    checkOutput("midrun rst mac_a", 32'(mac_a), 32'd0);
    checkOutput("midrun rst mac_b", 32'(mac_b), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 30; c++) tick();
    checkOutput("midrun rst no valid", 32'(validCount - v0), 32'd0);
    runDot("after reset", 19'd0);

`ifdef MAC_TIMEOUT_EN
    // MAC never answers: watchdog fires after 64 WAIT cycles
    for (int i = 0; i < VEC_LEN; i++) writeElem(1'b0, i, 8'd3);
    withholdDone = 1'b1;
    v0 = validCount;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && !mac_enable; c++) tick();
    checkOutput("timeout issue seen", 32'(mac_enable), 32'd1);
    for (int c = 0; c < 60; c++) tick();
    checkOutput("timeout not yet", 32'(mac_timeout), 32'd0);
    checkOutput("timeout still busy", 32'(busy), 32'd1);
    for (int c = 0; c < 10; c++) tick();
    checkOutput("timeout flag", 32'(mac_timeout), 32'd1);
    checkOutput("timeout idle", 32'(busy), 32'd0);
    checkOutput("timeout no valid", 32'(validCount - v0), 32'd0);
    withholdDone = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    checkOutput("timeout sticky", 32'(mac_timeout), 32'd1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
